pid_controller_mc: RTL and testbench

// Time-multiplexed multi-channel PID controller; one shared multiply/accumulate datapath serves NUM_CH loops.

---
 rtl/pid_pkg.sv | 40 ++++
 rtl/saturating_adder_signed.sv | 25 ++
 rtl/pid_controller_mc.sv | 207 ++++++++++++++++++++
 tb/tb_pid_controller_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and helpers for the multi-channel PID controller.
// Width helpers keep the datapath sizing in one place.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MULT,
    SUM,
    DONE
  } pid_state_t;

  function automatic int err_w(input int pv);
    return pv + 1;
  endfunction

  function automatic int dlt_w(input int pv);
    return pv + 2;
  endfunction

  // zero-extended gain (g+1 signed bits) times an x-bit signed operand
  function automatic int prod_w(input int g, input int x);
    return g + 1 + x;
  endfunction

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [31:0] sat_signed(
    input logic signed [31:0] x,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/saturating_adder_signed.sv
// Signed adder whose result is clamped to +/-LIMIT.
// One guard bit keeps the raw sum exact before clamping.
module saturating_adder_signed #(
  parameter int W     = 19,
  parameter int LIMIT = 4095
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  localparam logic signed [W:0] HI = (W+1)'(LIMIT);
  localparam logic signed [W:0] LO = -HI;

  logic signed [W:0] full;

  assign full = (W+1)'(a) + (W+1)'(b);

  always_comb begin
    sum = full[W-1:0];
    if (full > HI)      sum = HI[W-1:0];
    else if (full < LO) sum = LO[W-1:0];
  end

endmodule

// File: rtl/pid_controller_mc.sv
// Time-multiplexed PID controller: one multiply/accumulate path
// sweeps NUM_CH loops per start strobe.
module pid_controller_mc
  import pid_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int PV_WIDTH      = 9,
  parameter int GAIN_WIDTH    = 8,
  parameter int GAIN_FRAC     = 4,
  parameter int CONTROL_WIDTH = 16,
  parameter int I_BAND        = 5,
  parameter int I_LIMIT       = 4095
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                en,
  input  logic                                start,
  input  logic                                d_on_meas,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]        k_p,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]        k_i,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]        k_d,
  input  logic [NUM_CH*PV_WIDTH-1:0]          setpoint,
  input  logic [NUM_CH*PV_WIDTH-1:0]          feedback,
  input  logic signed [CONTROL_WIDTH-1:0]     out_min,
  input  logic signed [CONTROL_WIDTH-1:0]     out_max,
  output logic                                busy,
  output logic                                out_valid,
  output logic signed [NUM_CH*CONTROL_WIDTH-1:0] control_out,
  output logic [NUM_CH-1:0]                   sat_flag
);

  localparam int E_W = err_w(PV_WIDTH);
  localparam int D_W = dlt_w(PV_WIDTH);
  localparam int P_W = prod_w(GAIN_WIDTH, E_W);
  localparam int U_W = prod_w(GAIN_WIDTH, D_W);
  localparam int S_W = U_W + 2;
  localparam int C_W = ch_w(NUM_CH);
  localparam logic [C_W-1:0] LAST = C_W'(NUM_CH - 1);

  pid_state_t state;
  logic [C_W-1:0] ch;

  logic signed [E_W-1:0] e_r;
  logic signed [D_W-1:0] dlt_r;
  logic [PV_WIDTH-1:0]   fb_r;
  logic signed [P_W-1:0] u_p;
  logic signed [P_W-1:0] i_inc;
  logic signed [U_W-1:0] u_d;

  logic signed [P_W-1:0]           i_acc   [NUM_CH];
  logic signed [E_W-1:0]           prev_e  [NUM_CH];
  logic [PV_WIDTH-1:0]             prev_fb [NUM_CH];
  logic signed [CONTROL_WIDTH-1:0] ctrl    [NUM_CH];
  logic [NUM_CH-1:0] first;
  logic [NUM_CH-1:0] sat_hi;
  logic [NUM_CH-1:0] sat_lo;

  logic [PV_WIDTH-1:0]   sp_c;
  logic [PV_WIDTH-1:0]   fb_c;
  logic signed [E_W-1:0] e_c;
  logic signed [D_W-1:0] dlt_c;
  logic [GAIN_WIDTH-1:0] kp_c;
  logic [GAIN_WIDTH-1:0] ki_c;
  logic [GAIN_WIDTH-1:0] kd_c;

  assign sp_c = setpoint[int'(ch)*PV_WIDTH +: PV_WIDTH];
  assign fb_c = feedback[int'(ch)*PV_WIDTH +: PV_WIDTH];
  assign kp_c = k_p[int'(ch)*GAIN_WIDTH +: GAIN_WIDTH];
  assign ki_c = k_i[int'(ch)*GAIN_WIDTH +: GAIN_WIDTH];
  assign kd_c = k_d[int'(ch)*GAIN_WIDTH +: GAIN_WIDTH];

  assign e_c = $signed({1'b0, sp_c}) - $signed({1'b0, fb_c});
  assign dlt_c = d_on_meas
    ? D_W'($signed({1'b0, prev_fb[ch]}) - $signed({1'b0, fb_c}))
    : D_W'(e_c) - D_W'(prev_e[ch]);

  logic signed [P_W-1:0] i_sum;
  logic signed [P_W-1:0] i_new;
  logic signed [E_W-1:0] e_abs;
  logic                  in_band;
  logic                  hold;
  logic signed [S_W-1:0] sum_c;
  logic signed [S_W-1:0] raw_c;
  logic signed [31:0]    raw32;
  logic signed [31:0]    clip32;
  logic                  hi_c;
  logic                  lo_c;

  saturating_adder_signed #(
    .W     (P_W),
    .LIMIT (I_LIMIT)
  ) u_iadd (
    .a   (i_acc[ch]),
    .b   (i_inc),
    .sum (i_sum)
  );

  assign e_abs   = e_r[E_W-1] ? -e_r : e_r;
  assign in_band = int'(e_abs) < I_BAND;
  // back-calculation: don't push further into a clip we already hit
  assign hold = (sat_hi[ch] && !e_r[E_W-1] && (e_r != '0))
             || (sat_lo[ch] && e_r[E_W-1]);
  assign i_new = (in_band && !hold) ? i_sum : i_acc[ch];

  assign sum_c  = S_W'(u_p) + S_W'(i_new) + S_W'(u_d);
  assign raw_c  = sum_c >>> GAIN_FRAC;
  assign raw32  = 32'(raw_c);
  assign clip32 = sat_signed(raw32, 32'(out_min), 32'(out_max));
  assign hi_c   = raw32 > 32'(out_max);
  assign lo_c   = raw32 < 32'(out_min);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ch        <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      e_r       <= '0;
      dlt_r     <= '0;
      fb_r      <= '0;
      u_p       <= '0;
      i_inc     <= '0;
      u_d       <= '0;
      first     <= '1;
      sat_hi    <= '0;
      sat_lo    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        i_acc[i]   <= '0;
        prev_e[i]  <= '0;
        prev_fb[i] <= '0;
        ctrl[i]    <= '0;
      end
    end else if (!en) begin
      state     <= IDLE;
      ch        <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      e_r       <= '0;
      dlt_r     <= '0;
      fb_r      <= '0;
      u_p       <= '0;
      i_inc     <= '0;
      u_d       <= '0;
      first     <= '1;
      sat_hi    <= '0;
      sat_lo    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        i_acc[i]   <= '0;
        prev_e[i]  <= '0;
        prev_fb[i] <= '0;
        ctrl[i]    <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            ch    <= '0;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          e_r   <= e_c;
          dlt_r <= dlt_c;
          fb_r  <= fb_c;
          state <= MULT;
        end
        MULT: begin
          u_p   <= P_W'($signed({1'b0, kp_c})) * P_W'(e_r);
          i_inc <= P_W'($signed({1'b0, ki_c})) * P_W'(e_r);
          u_d   <= first[ch] ? '0
                 : U_W'($signed({1'b0, kd_c})) * U_W'(dlt_r);
          state <= SUM;
        end
        SUM: begin
          i_acc[ch]   <= i_new;
          ctrl[ch]    <= clip32[CONTROL_WIDTH-1:0];
          sat_hi[ch]  <= hi_c;
          sat_lo[ch]  <= lo_c;
          prev_e[ch]  <= e_r;
          prev_fb[ch] <= fb_r;
          first[ch]   <= 1'b0;
          if (ch == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sat_flag = sat_hi | sat_lo;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign control_out[g*CONTROL_WIDTH +: CONTROL_WIDTH] = ctrl[g];
  end

endmodule

// File: tb/tb_pid_controller_mc.sv
// Directed bench for pid_controller_mc with hand-computed results.
// Each step drives inputs, runs a sweep and asserts the outputs.
module tb_pid_controller_mc;

  localparam int N  = 4;
  localparam int PW = 9;
  localparam int GW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic start = 1'b0;
  logic d_on_meas = 1'b0;
  logic [N*GW-1:0] k_p = '0;
  logic [N*GW-1:0] k_i = '0;
  logic [N*GW-1:0] k_d = '0;
  logic [N*PW-1:0] setpoint = '0;
  logic [N*PW-1:0] feedback = '0;
  logic signed [CW-1:0] out_min = -16'sd1000;
  logic signed [CW-1:0] out_max = 16'sd1000;
  logic busy;
  logic out_valid;
  logic signed [N*CW-1:0] control_out;
  logic [N-1:0] sat_flag;

  int n_ass = 0;
  int n_fail = 0;
  int pulses;

  always #5 clk = ~clk;

  pid_controller_mc dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .start       (start),
    .d_on_meas   (d_on_meas),
    .k_p         (k_p),
    .k_i         (k_i),
    .k_d         (k_d),
    .setpoint    (setpoint),
    .feedback    (feedback),
    .out_min     (out_min),
    .out_max     (out_max),
    .busy        (busy),
    .out_valid   (out_valid),
    .control_out (control_out),
    .sat_flag    (sat_flag)
  );

  function automatic logic signed [31:0] ctrl(input int c);
    return 32'($signed(control_out[c*CW +: CW]));
  endfunction

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_ass++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // start a sweep from idle and wait (bounded) for out_valid
  task automatic sweep();
    int lat;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 13);
  endtask

  task automatic en_clear();
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ctrl", 32'(control_out != '0), 0);
    chk("rst_sat", 32'(sat_flag), 0);
    @(negedge clk); reset = 1'b0;

    // proportional: e=10, kp=2.0 -> 20
    setpoint[8:0] = 9'd100; feedback[8:0] = 9'd90; k_p[7:0] = 8'd32;
    sweep();
    chk("p_ctrl0", ctrl(0), 20);
    chk("p_sat0", 32'(sat_flag[0]), 0);
    chk("p_ctrl1", ctrl(1), 0);
    @(posedge clk); #1;
    chk("p_valid_pulse", 32'(out_valid), 0);
    chk("p_busy_after", 32'(busy), 0);

    // integral: e=3, ki=1.0 accumulates 3 per sweep
    k_p[7:0] = 8'd0; k_i[7:0] = 8'd16; feedback[8:0] = 9'd97;
    sweep(); chk("i_sweep1", ctrl(0), 3);
    sweep(); chk("i_sweep2", ctrl(0), 6);
    sweep(); chk("i_sweep3", ctrl(0), 9);
    feedback[8:0] = 9'd90;
    sweep(); chk("i_out_band_hold", ctrl(0), 9);

    // clip at both limits
    en_clear();
    chk("en_clear_ctrl", ctrl(0), 0);
    k_i[7:0] = 8'd0; k_p[7:0] = 8'd255;
    setpoint[8:0] = 9'd255; feedback[8:0] = 9'd0;
    k_p[15:8] = 8'd255; setpoint[17:9] = 9'd0; feedback[17:9] = 9'd255;
    sweep();
    chk("sat_hi_ctrl", ctrl(0), 1000);
    chk("sat_hi_flag", 32'(sat_flag[0]), 1);
    chk("sat_lo_ctrl", ctrl(1), -1000);
    chk("sat_lo_flag", 32'(sat_flag[1]), 1);

    // anti-windup: e=4 in band, kp=255 drives into out_max=50
    en_clear();
    k_p[15:8] = 8'd0; setpoint[17:9] = 9'd0; feedback[17:9] = 9'd0;
    k_i[7:0] = 8'd16; setpoint[8:0] = 9'd104; feedback[8:0] = 9'd100;
    out_max = 16'sd50;
    sweep(); chk("aw_sweep1", ctrl(0), 50);
    sweep(); chk("aw_sweep2", ctrl(0), 50);
    k_p[7:0] = 8'd0; out_max = 16'sd1000;
    sweep();
    chk("aw_frozen", ctrl(0), 4);
    chk("aw_unsat", 32'(sat_flag[0]), 0);
    sweep(); chk("aw_resume", ctrl(0), 8);

    // derivative on measurement
    en_clear();
    k_i[7:0] = 8'd0; k_d[7:0] = 8'd16; d_on_meas = 1'b1;
    setpoint[8:0] = 9'd60; feedback[8:0] = 9'd50;
    sweep(); chk("d_first", ctrl(0), 0);
    feedback[8:0] = 9'd40;
    sweep(); chk("d_meas_step", ctrl(0), 10);
    setpoint[8:0] = 9'd80;
    sweep(); chk("d_sp_step", ctrl(0), 0);
    d_on_meas = 1'b0;
    sweep(); chk("d_err_flat", ctrl(0), 0);
    setpoint[8:0] = 9'd90;
    sweep(); chk("d_err_step", ctrl(0), 10);

    // en dropped mid-sweep
    d_on_meas = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ctrl", ctrl(0), 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      pulses += 32'(out_valid);
    end
    chk("abort_no_valid", pulses, 0);
    en = 1'b1;
    sweep(); chk("reen_first", ctrl(0), 0);
    feedback[8:0] = 9'd30;
    sweep(); chk("reen_d", ctrl(0), 10);

    // start while busy is ignored
    k_p[7:0] = 8'd16;
    repeat (2) @(negedge clk);
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = (i == 3);
      pulses += 32'(out_valid);
    end
    start = 1'b0;
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_ctrl", ctrl(0), 60);

    // async reset mid-sweep
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ctrl", ctrl(0), 0);
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk); reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_ass, n_fail);
    $finish;
  end

endmodule
